mmm_operand_serializer: RTL and testbench

Parallel-in, serial-out operand feeder for the Montgomery modular multiplier (MMM) datapath. It loads operand A in parallel and presents one bit a_i per enabled iteration, LSB first, to the processing element. The iteration-result register consumes on the other side of the same per-iteration `en` interface. It provides start/busy/done handshaking and an iteration index for the MMM controller.

---
 rtl/mmm_operand_serializer_if.sv | 28 ++
 rtl/mmm_operand_serializer.sv | 81 ++++++++
 tb/tb_mmm_operand_serializer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmm_operand_serializer_if.sv
// Bus between the MMM controller (master) and the operand serializer (slave).
// Carries the per-iteration enable, abort, load request, operand and the serial bit stream.
interface mmm_operand_serializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  // start is only looked at while the serializer is idle. ai is consumed on every
  // rising edge where ai_valid && en; en low holds ai and bit_idx. clr overrides both.
  logic             en;
  logic             clr;
  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic             ai;
  logic             ai_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_idx;

  modport master (
    output en, clr, start, operand_a,
    input  ai, ai_valid, busy, done, bit_idx
  );

  modport slave (
    input  en, clr, start, operand_a,
    output ai, ai_valid, busy, done, bit_idx
  );
endinterface

// File: rtl/mmm_operand_serializer.sv
// Parallel-in, serial-out operand feeder for the MMM datapath (IDLE -> SHIFT -> DONE).
// Define SER_MSB_FIRST_EN to present the operand MSB first instead of LSB first.
module mmm_operand_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mmm_operand_serializer_if.slave bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] sr_next;
  logic             head_bit;

`ifdef SER_MSB_FIRST_EN
  assign sr_next  = sr << 1;
  assign head_bit = sr[WIDTH-1];
`else
  assign sr_next  = sr >> 1;
  assign head_bit = sr[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
    end else if (bus.clr) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr    <= bus.operand_a;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.en) begin
            sr <= sr_next;
            // The last bit leaves idx at WIDTH-1 so no wrapped index is ever shown.
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // All outputs decode registered state only.
  assign bus.ai       = (state == SHIFT) ? head_bit : 1'b0;
  assign bus.ai_valid = (state == SHIFT);
  assign bus.busy     = (state == SHIFT) || (state == DONE);
  assign bus.done     = (state == DONE);
  assign bus.bit_idx  = idx;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mmm_operand_serializer.sv
// Self-checking bench for mmm_operand_serializer: vector table, random runs against a
// presentation-order model, and hand sequences for reset, clr and back-to-back starts.
module tb_mmm_operand_serializer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int BUDGET = 80;
`ifdef SER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_cmp;
  int         n_err;
  logic [0:0] exp_q[$];

  mmm_operand_serializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mmm_operand_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [WIDTH-1:0] op;
    logic [63:0]      en_seq;
    int               exp_edges;
    bit               mid_start;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the bits in the order they must appear on ai.
  function automatic void load_model(input logic [WIDTH-1:0] op);
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++)
      exp_q.push_back(MSB_FIRST ? op[WIDTH-1-i] : op[i]);
  endfunction

  // Edges after the start edge until done is visible: one past the WIDTH-th enabled cycle.
  function automatic int model_done_edges(input logic [63:0] en_seq);
    int ones;
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      if (en_seq[k]) ones++;
      if (ones == WIDTH) return k + 1;
    end
    return -1;
  endfunction

  // Driver + scoreboard for one operation. Entered and left at a negedge.
  task automatic run_op(input logic [WIDTH-1:0] op, input logic [63:0] en_seq,
                        input int exp_edges, input bit mid_start, input bit keep_start);
    int  edges;
    bit  done_seen;
    load_model(op);
    bus.start     = 1'b1;
    bus.operand_a = op;
    bus.en        = 1'b0;
    @(posedge clk);
    edges     = 0;
    done_seen = 1'b0;
    while (!done_seen && edges < BUDGET) begin
      @(negedge clk);
      if (edges == 0) begin
        bus.start     = keep_start;
        bus.operand_a = ~op;
      end
      if (mid_start && edges == 2) begin
        bus.start     = 1'b1;
        bus.operand_a = '1;
      end
      if (mid_start && edges == 3) bus.start = keep_start;
      if (bus.done === 1'b1) begin
        done_seen = 1'b1;
        chk("done_latency", edges, exp_edges);
        chk("done_ai", bus.ai, 1'b0);
        chk("done_valid", bus.ai_valid, 1'b0);
        chk("done_busy", bus.busy, 1'b1);
        chk("done_all_bits", exp_q.size(), 0);
      end else if (exp_q.size() == 0) begin
        chk("done_missing", bus.done, 1'b1);
        edges = BUDGET;
      end else begin
        chk("shift_valid", bus.ai_valid, 1'b1);
        chk("shift_busy", bus.busy, 1'b1);
        chk("shift_idx", bus.bit_idx, WIDTH - exp_q.size());
        chk("shift_ai", bus.ai, exp_q[0]);
        bus.en = en_seq[edges];
        @(posedge clk);
        if (bus.en) void'(exp_q.pop_front());
        edges++;
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("post_busy", bus.busy, 1'b0);
    chk("post_done", bus.done, 1'b0);
    chk("post_valid", bus.ai_valid, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{op: 8'hA5, en_seq: 64'hFFFF_FFFF_FFFF_FFFF, exp_edges: 8,  mid_start: 1'b0};
    vecs[1] = '{op: 8'h3C, en_seq: 64'h9999_9999_9999_9999, exp_edges: 16, mid_start: 1'b0};
    vecs[2] = '{op: 8'hA5, en_seq: 64'hFFFF_FFFF_FFFF_FFFF, exp_edges: 8,  mid_start: 1'b1};
    vecs[3] = '{op: 8'h80, en_seq: 64'hAAAA_AAAA_AAAA_AAAA, exp_edges: 16, mid_start: 1'b0};
    vecs[4] = '{op: 8'h01, en_seq: 64'hFFFF_FFFF_FFFF_FFFE, exp_edges: 9,  mid_start: 1'b0};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.start = 1'b0;
    bus.operand_a = '0;
    repeat (2) @(negedge clk);
    chk("rst_ai", bus.ai, 1'b0);
    chk("rst_valid", bus.ai_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_idx", bus.bit_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", state_dbg, 0);

    for (int v = 0; v < 5; v++)
      run_op(vecs[v].op, vecs[v].en_seq, vecs[v].exp_edges, vecs[v].mid_start, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic [WIDTH-1:0] op;
      logic [63:0]      seq;
      op  = WIDTH'($urandom_range(0, 255));
      seq = {$urandom, $urandom} | 64'hFFFF_0000_0000_0000;
      run_op(op, seq, model_done_edges(seq), ($urandom_range(0, 1) == 1), 1'b0);
    end

    // back-to-back with start held high: second run accepted right after the idle cycle
    run_op(8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b0, 1'b1);
    run_op(8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b0, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_drain_busy", bus.busy, 1'b0);

    // asynchronous reset mid-operation
    bus.start = 1'b1;
    bus.operand_a = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_idx", bus.bit_idx, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_ai", bus.ai, 1'b0);
    chk("arst_valid", bus.ai_valid, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_idx", bus.bit_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("arst_idle", state_dbg, 0);
      chk("arst_no_done", bus.done, 1'b0);
    end
    bus.en = 1'b0;

    // clr at bit_idx 4 aborts without a done pulse
    bus.start = 1'b1;
    bus.operand_a = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k < 20 && bus.bit_idx != 4; k++) @(negedge clk);
    chk("clr_reach_idx4", bus.bit_idx, 4);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    chk("clr_busy", bus.busy, 1'b0);
    chk("clr_valid", bus.ai_valid, 1'b0);
    chk("clr_idx", bus.bit_idx, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("clr_no_done", bus.done, 1'b0);
    end

    // clr and start together in IDLE: stays idle
    bus.clr = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("clr_start_idle", state_dbg, 0);
    chk("clr_start_busy", bus.busy, 1'b0);
    bus.clr = 1'b0;
    bus.start = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    chk("final_idle", state_dbg, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
